fixpoint_engine: RTL and testbench

FIXPOINT_ENGINE -- requirements
Module: fixpoint_engine

---
 rtl/fixpoint_pkg.sv | 10 +
 rtl/fixpoint_step.sv | 15 +
 rtl/fixpoint_engine.sv | 129 ++++++++++++
 tb/tb_fixpoint_engine.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fixpoint_pkg.sv
// fixpoint_pkg: shared FSM/result enums and rotate helper for the fixpoint engine
package fixpoint_pkg;
  localparam int MAXW = 64;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {FIX = 2'd0, BUG = 2'd1, TIMEOUT = 2'd2} code_t;
  // rotate the low w bits of v left by one; bits above w must be zero
  function automatic logic [MAXW-1:0] rotl(input logic [MAXW-1:0] v, input int w);
    return ((v << 1) | (v >> (w - 1))) & ((MAXW'(1) << w) - MAXW'(1));
  endfunction
endpackage

// File: rtl/fixpoint_step.sv
// fixpoint_step: one combinational propagation step, nxt = (cur | rotl(cur) & prop) & ~kill
module fixpoint_step
  import fixpoint_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] prop_mask,
  input  logic [W-1:0] kill_mask,
  output logic [W-1:0] nxt
);
  logic [W-1:0] rot;
  assign rot = W'(rotl(MAXW'(cur), W));
  assign nxt = (cur | (rot & prop_mask)) & ~kill_mask;
endmodule

// File: rtl/fixpoint_engine.sv
// fixpoint_engine: iterates a propagation step to a fixpoint, bug hit or timeout; FIXPOINT_TRACE_EN adds a step trace
module fixpoint_engine
  import fixpoint_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_ITER = 16,
  parameter int CW       = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [W-1:0]  init_state,
  input  logic [W-1:0]  prop_mask,
  input  logic [W-1:0]  kill_mask,
  input  logic [W-1:0]  bad_mask,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [1:0]    res_code,
  output logic [CW-1:0] res_iter,
  output logic [W-1:0]  res_state
`ifdef FIXPOINT_TRACE_EN
  ,
  output logic          trace_valid,
  output logic [W-1:0]  trace_state
`endif
);
  state_t state_q, state_d;
  code_t code_q, code_d;
  logic [W-1:0] cur_q, cur_d, prop_q, prop_d, kill_q, kill_d, bad_q, bad_d, rstate_q, rstate_d, nxt;
  logic [CW-1:0] iter_q, iter_d, riter_q, riter_d;
  logic bad_hit, fix_hit, max_hit, stop, advance;

  fixpoint_step #(.W(W)) u_step (
    .cur(cur_q),
    .prop_mask(prop_q),
    .kill_mask(kill_q),
    .nxt(nxt)
  );

  assign bad_hit     = |(cur_q & bad_q);
  assign fix_hit     = nxt == cur_q;
  assign max_hit     = iter_q == CW'(MAX_ITER);
  assign stop        = bad_hit || fix_hit || max_hit;
  assign advance     = state_q == RUN && !stop;
  assign start_ready = state_q == IDLE;
  assign res_valid   = state_q == DONE;
  assign res_code    = code_q;
  assign res_iter    = riter_q;
  assign res_state   = rstate_q;

  // state, working vector, captured masks and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      code_q   <= FIX;
      cur_q    <= '0;
      prop_q   <= '0;
      kill_q   <= '0;
      bad_q    <= '0;
      rstate_q <= '0;
      iter_q   <= '0;
      riter_q  <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      cur_q    <= cur_d;
      prop_q   <= prop_d;
      kill_q   <= kill_d;
      bad_q    <= bad_d;
      rstate_q <= rstate_d;
      iter_q   <= iter_d;
      riter_q  <= riter_d;
    end
  end

  // accept a job, take one prioritized decision per RUN cycle, hold the result until consumed
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cur_d    = cur_q;
    prop_d   = prop_q;
    kill_d   = kill_q;
    bad_d    = bad_q;
    rstate_d = rstate_q;
    iter_d   = iter_q;
    riter_d  = riter_q;
    case (state_q)
      IDLE: if (start_valid) begin
        state_d = RUN;
        cur_d   = init_state;
        iter_d  = '0;
        prop_d  = prop_mask;
        kill_d  = kill_mask;
        bad_d   = bad_mask;
      end
      RUN: if (stop) begin
        state_d  = DONE;
        code_d   = bad_hit ? BUG : (fix_hit ? FIX : TIMEOUT);
        riter_d  = iter_q;
        rstate_d = cur_q;
      end else begin
        cur_d  = nxt;
        iter_d = iter_q + 1'b1;
      end
      DONE: state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

`ifdef FIXPOINT_TRACE_EN
  logic tv_q, tv_d;
  logic [W-1:0] ts_q, ts_d;
  assign tv_d        = advance;
  assign ts_d        = advance ? nxt : ts_q;
  assign trace_valid = tv_q;
  assign trace_state = ts_q;
  // one-cycle pulse carrying the new state for every advancing step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv_q <= 1'b0;
      ts_q <= '0;
    end else begin
      tv_q <= tv_d;
      ts_q <= ts_d;
    end
  end
`endif
endmodule

// File: tb/tb_fixpoint_engine.sv
// tb_fixpoint_engine: directed and randomized checks of fixpoint_engine against a behavioural model
module tb_fixpoint_engine;
  logic clk = 1'b0, rst = 1'b1;
  logic sv = 1'b0, rr = 1'b0, sv4 = 1'b0, rr4 = 1'b0;
  logic [7:0] init_state = '0, prop_mask = '0, kill_mask = '0, bad_mask = '0;
  logic start_ready, res_valid, start_ready4, res_valid4;
  logic [1:0] res_code, res_code4;
  logic [4:0] res_iter;
  logic [2:0] res_iter4;
  logic [7:0] res_state, res_state4;
  int checks = 0, failures = 0;
`ifdef FIXPOINT_TRACE_EN
  logic tv, tv4;
  logic [7:0] ts, ts4;
`endif

  always #5 clk = ~clk;

  fixpoint_engine #(.W(8), .MAX_ITER(16)) dut (
    .clk(clk), .rst(rst), .start_valid(sv), .start_ready(start_ready),
    .init_state(init_state), .prop_mask(prop_mask), .kill_mask(kill_mask), .bad_mask(bad_mask),
    .res_valid(res_valid), .res_ready(rr), .res_code(res_code), .res_iter(res_iter), .res_state(res_state)
`ifdef FIXPOINT_TRACE_EN
    , .trace_valid(tv), .trace_state(ts)
`endif
  );

  fixpoint_engine #(.W(8), .MAX_ITER(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(start_ready4),
    .init_state(init_state), .prop_mask(prop_mask), .kill_mask(kill_mask), .bad_mask(bad_mask),
    .res_valid(res_valid4), .res_ready(rr4), .res_code(res_code4), .res_iter(res_iter4), .res_state(res_state4)
`ifdef FIXPOINT_TRACE_EN
    , .trace_valid(tv4), .trace_state(ts4)
`endif
  );

  // reference: iterate the rule set directly
  task automatic model(input logic [7:0] i, p, k, b, input int mx,
                       output logic [1:0] c, output int it, output logic [7:0] st);
    logic [7:0] cur, n;
    cur = i;
    for (int s = 0; s <= mx; s++) begin
      n = (cur | ({cur[6:0], cur[7]} & p)) & ~k;
      if ((cur & b) != 0) begin c = 2'd1; it = s; st = cur; return; end
      if (n == cur) begin c = 2'd0; it = s; st = cur; return; end
      if (s == mx) begin c = 2'd2; it = s; st = cur; return; end
      cur = n;
    end
  endtask

  task automatic launch(input bit four, input logic [7:0] i, p, k, b);
    @(negedge clk);
    checks++;
    if ((four ? start_ready4 : start_ready) !== 1'b1) begin
      failures++;
      $display("FAIL launch_ready got=%b want=1", four ? start_ready4 : start_ready);
    end
    init_state = i; prop_mask = p; kill_mask = k; bad_mask = b;
    if (four) sv4 = 1'b1; else sv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv = 1'b0; sv4 = 1'b0;
    init_state = $urandom; prop_mask = $urandom; kill_mask = $urandom; bad_mask = $urandom;
  endtask

  task automatic wait_res(input bit four, output logic [1:0] c, output int it,
                          output logic [7:0] st, output int lat);
    lat = 0;
    while (!(four ? res_valid4 : res_valid) && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    c  = four ? res_code4 : res_code;
    it = four ? int'(res_iter4) : int'(res_iter);
    st = four ? res_state4 : res_state;
    checks++;
    if (lat >= 100) begin failures++; $display("FAIL res_timeout got=no_result want=res_valid"); end
  endtask

  task automatic release_res(input bit four);
    if (four) rr4 = 1'b1; else rr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr = 1'b0; rr4 = 1'b0;
    checks++;
    if ((four ? start_ready4 : start_ready) !== 1'b1 || (four ? res_valid4 : res_valid) !== 1'b0) begin
      failures++;
      $display("FAIL release got=ready%b/valid%b want=ready1/valid0",
               four ? start_ready4 : start_ready, four ? res_valid4 : res_valid);
    end
  endtask

  task automatic job(input string name, input bit four, input logic [7:0] i, p, k, b,
                     input logic [1:0] ec, input int eit, input logic [7:0] est);
    logic [1:0] c; int it, lat; logic [7:0] st;
    launch(four, i, p, k, b);
    wait_res(four, c, it, st, lat);
    checks++;
    if (c !== ec || it != eit || st !== est || lat != eit + 1) begin
      failures++;
      $display("FAIL %s got=code%0d/iter%0d/state%h/lat%0d want=code%0d/iter%0d/state%h/lat%0d",
               name, c, it, st, lat, ec, eit, est, eit + 1);
    end
    release_res(four);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || res_code !== 2'd0 || res_iter !== 5'd0 ||
        res_state !== 8'h00 || start_ready4 !== 1'b1 || res_valid4 !== 1'b0) begin
      failures++;
      $display("FAIL reset got=rdy%b val%b code%0d iter%0d st%h want=rdy1 val0 code0 iter0 st00",
               start_ready, res_valid, res_code, res_iter, res_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    job("fix_full", 1'b0, 8'h01, 8'hFF, 8'h00, 8'h00, 2'd0, 7, 8'hFF);
    job("bug_bit4", 1'b0, 8'h01, 8'hFF, 8'h00, 8'h10, 2'd1, 4, 8'h1F);
    job("fix_kill", 1'b0, 8'h01, 8'hFF, 8'h04, 8'h00, 2'd0, 1, 8'h03);
    job("bug_init", 1'b0, 8'h81, 8'hFF, 8'h00, 8'h80, 2'd1, 0, 8'h81);
    job("timeout4", 1'b1, 8'h01, 8'hFF, 8'h00, 8'h00, 2'd2, 4, 8'h1F);
    job("fix_init", 1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 2'd0, 0, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] i, p, k, b, est; logic [1:0] ec; int eit;
    for (int n = 0; n < 24; n++) begin
      i = 8'($urandom); p = 8'($urandom | $urandom); k = 8'($urandom & $urandom & $urandom);
      b = 8'($urandom & $urandom & $urandom);
      if (n % 3 == 0) i = i & 8'h03;
      model(i, p, k, b, n[0] ? 4 : 16, ec, eit, est);
      job(n[0] ? "rand_m4" : "rand_m16", n[0], i, p, k, b, ec, eit, est);
    end
  endtask

  task automatic test_reset_midrun();
    launch(1'b0, 8'h01, 8'hFF, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || res_state !== 8'h00 || res_iter !== 5'd0) begin
      failures++;
      $display("FAIL midrun_reset got=rdy%b val%b st%h it%0d want=rdy1 val0 st00 it0",
               start_ready, res_valid, res_state, res_iter);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
        failures++;
        $display("FAIL aborted_job got=val%b rdy%b want=val0 rdy1", res_valid, start_ready);
      end
    end
    job("after_reset", 1'b0, 8'h01, 8'hFF, 8'h04, 8'h00, 2'd0, 1, 8'h03);
  endtask

  task automatic test_backpressure();
    logic [1:0] c; int it, lat; logic [7:0] st;
    launch(1'b0, 8'h01, 8'hFF, 8'h00, 8'h00);
    wait_res(1'b0, c, it, st, lat);
    for (int n = 0; n < 5; n++) begin
      sv = 1'b1; init_state = 8'h80; prop_mask = 8'h00; kill_mask = 8'h00; bad_mask = 8'h80;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || res_code !== 2'd0 ||
          res_iter !== 5'd7 || res_state !== 8'hFF) begin
        failures++;
        $display("FAIL hold got=val%b rdy%b code%0d it%0d st%h want=val1 rdy0 code0 it7 stFF",
                 res_valid, start_ready, res_code, res_iter, res_state);
      end
    end
    sv = 1'b0;
    release_res(1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start got=rdy%b val%b want=rdy1 val0", start_ready, res_valid);
    end
  endtask

  task automatic test_back_to_back();
    job("b2b_a", 1'b0, 8'h10, 8'h0F, 8'h00, 8'h00, 2'd0, 0, 8'h10);
    job("b2b_b", 1'b0, 8'h08, 8'h30, 8'h00, 8'h20, 2'd1, 2, 8'h38);
    job("b2b_c", 1'b1, 8'h80, 8'h01, 8'h00, 8'h00, 2'd0, 1, 8'h81);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_midrun();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
